alu_writeback_stage: RTL
========================

# alu_writeback_stage

Registers the combinational result and flags from the simple ALU and distributes them to the rest of the back end. Each accepted operation produces three things: a physical register file write, a one-cycle bypass broadcast, and a completion record for the active list. The block sits directly after the simple ALU in the execute lane. A small completion FIFO absorbs active-list backpressure and drives the lane's issue stall.

## Interface
- DATA_W, 32, result width
- FLAGS_W, 6, execution-flag width; bit2 = executed, bit1 = exception, bit0 = mispredict, bits 5:3 passed through
- PREG_W, 7, physical register tag width
- AL_W, 7, active-list index width
- DEPTH, 2, completion FIFO entries (power of two, at least 2)
- EXC_W, 16, exception counter width

Ports:
- clk in 1: single clock; all state changes on rising edge
- reset_n in 1: asynchronous, active-low reset
- valid_i in 1: ALU output valid this cycle
- result_i in DATA_W: ALU result
- flags_i in FLAGS_W: ALU flags
- dest_valid_i in 1: instruction writes a destination
- dest_tag_i in PREG_W: destination physical register
- al_id_i in AL_W: active-list index
- ready_o out 1: stage can accept; low stalls issue
- flush_i in 1: mispredict recovery; clears all in-flight state
- rf_we_o out 1: register file write enable
- rf_addr_o out PREG_W: register file write address
- rf_data_o out DATA_W: register file write data
- byp_valid_o out 1: bypass broadcast valid
- byp_tag_o out PREG_W: bypass tag
- byp_data_o out DATA_W: bypass data
- cmpl_valid_o out 1: completion FIFO head valid
- cmpl_ready_i in 1: active list accepts the head
- cmpl_al_id_o out AL_W: head active-list index
- cmpl_flags_o out FLAGS_W: head flags
- exc_count_o out EXC_W: saturating count of accepted exceptions

## Operation
- Accept: an operation is accepted when valid_i and ready_o are both high and flush_i is low.
- ready_o = (count < DEPTH). It is a function of registered state only and never depends on cmpl_ready_i.
- Write qualification: wr = dest_valid_i and flags_i[2].
- On accept with wr = 1: the register file write and the bypass broadcast are both registered and appear on the next cycle. Each lasts exactly one cycle. They are then cleared unless another qualifying operation is accepted.
- On accept with wr = 0: no register file write, no bypass. A completion record is still pushed.
- Every accept pushes {al_id_i, flags_i} into the FIFO.
- FIFO head: cmpl_valid_o = (count != 0). The head pops when cmpl_valid_o and cmpl_ready_i are both high.
- Count update on the same cycle: push only → count + 1; pop only → count − 1; push and pop together → count unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Exception counter: on accept with flags_i[1] = 1, exc_count_o increments. It saturates at all-ones. Flush does not clear it.
- Flush: flush_i has priority over everything else. In the same edge it:
  - clears count and both pointers;
  - clears rf_we_o and byp_valid_o;
  - drops the input presented that cycle;
  - suppresses any pop.

## Timing
- Reset values: rf_we_o = 0, byp_valid_o = 0, cmpl_valid_o = 0, exc_count_o = 0, and all data/tag outputs = 0.
- ready_o is 1 while reset is asserted and after release.
- Latency:
  - accept → rf_we_o/byp_valid_o: 1 cycle;
  - accept → cmpl_valid_o on an empty FIFO: 1 cycle.
- Completion records come out in acceptance order.
- While the FIFO is full, ready_o = 0. A pop in that cycle raises ready_o only on the following cycle.
- Head payload stays stable while cmpl_valid_o is high and cmpl_ready_i is low.
- Reset asserted mid-operation: all state clears immediately, asynchronously.

## Structure
- The shared execute package holds:
  - flag bit-index constants FLAG_EXECUTED = 2, FLAG_EXCEPTION = 1, FLAG_MISPREDICT = 0;
  - a completion-record struct {al_id, flags}.
- One sub-module: cmpl_fifo. It is a parameterised DEPTH-entry FIFO with count, and flush and async-reset inputs.
- Write/bypass registers and the exception counter live at the top level.

## Test plan
- Reset: after reset_n is released → ready_o = 1, all valids 0, exc_count_o = 0.
- Single operation: accept result 0x0000_00FF, flags 0b010100, tag 5, al_id 3, with cmpl_ready_i = 1. One cycle later the bench must see, in the same cycle:
  - rf_we_o = 1, addr 5, data 0xFF;
  - byp_valid_o = 1, tag 5;
  - cmpl_valid_o = 1, al_id 3.
  
  On the following cycle all of these are 0.
- Backpressure: hold cmpl_ready_i = 0 and accept al_id 1, 2 → ready_o = 0. Raise cmpl_ready_i → pops come out as 1 then 2, and ready_o returns to 1 the cycle after the first pop.
- Simultaneous push/pop at count = 1 → count stays 1, and records stay in order.
- Exceptions and non-writing ops:
  - flags bit1 set three times → exc_count_o = 3;
  - dest_valid_i = 0 → no rf_we_o, but a completion record is still pushed.
- Flush with two queued entries plus a valid input in the same cycle → next cycle cmpl_valid_o = 0, rf_we_o = 0, ready_o = 1, and the dropped input never appears.

Source files
------------

// File: rtl/alu_writeback_stage_pkg.sv
// Shared execute-lane definitions: flag bit positions and the completion record
// handed to the active list.
package alu_writeback_stage_pkg;

   localparam int unsigned FLAG_EXECUTED   = 2;
   localparam int unsigned FLAG_EXCEPTION  = 1;
   localparam int unsigned FLAG_MISPREDICT = 0;

   localparam int unsigned CMPL_AL_W    = 7;
   localparam int unsigned CMPL_FLAGS_W = 6;

   typedef struct packed {
      logic [CMPL_AL_W-1:0]    al_id;
      logic [CMPL_FLAGS_W-1:0] flags;
   } cmpl_rec_t;

endpackage

// File: rtl/alu_writeback_stage_cmpl_fifo.sv
// Small completion FIFO with occupancy count; flush empties it in one edge and
// suppresses any push or pop presented in that cycle.
module cmpl_fifo #(
   parameter int unsigned W     = 13,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push_s;
   logic          pop_s;

   assign push_s  = push_i && !flush_i && (count_q != DEPTH_C);
   assign pop_s   = pop_i && !flush_i && (count_q != {CW{1'b0}});
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {W{1'b0}};
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else if (flush_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: registers the ALU result into a register-file write and a
// bypass broadcast, and queues completion records for the active list.
module alu_writeback_stage
   import alu_writeback_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned FLAGS_W = 6,
   parameter int unsigned PREG_W  = 7,
   parameter int unsigned AL_W    = 7,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned EXC_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               valid_i,
   input  logic [DATA_W-1:0]  result_i,
   input  logic [FLAGS_W-1:0] flags_i,
   input  logic               dest_valid_i,
   input  logic [PREG_W-1:0]  dest_tag_i,
   input  logic [AL_W-1:0]    al_id_i,
   output logic               ready_o,
   input  logic               flush_i,
   output logic               rf_we_o,
   output logic [PREG_W-1:0]  rf_addr_o,
   output logic [DATA_W-1:0]  rf_data_o,
   output logic               byp_valid_o,
   output logic [PREG_W-1:0]  byp_tag_o,
   output logic [DATA_W-1:0]  byp_data_o,
   output logic               cmpl_valid_o,
   input  logic               cmpl_ready_i,
   output logic [AL_W-1:0]    cmpl_al_id_o,
   output logic [FLAGS_W-1:0] cmpl_flags_o,
   output logic [EXC_W-1:0]   exc_count_o
);

   localparam int unsigned   CW      = $clog2(DEPTH) + 1;
   localparam int unsigned   RW      = AL_W + FLAGS_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]     count_s;
   logic [RW-1:0]     head_s;
   logic              accept_s;
   logic              wr_s;

   logic              wb_we_q,   wb_we_d;
   logic [PREG_W-1:0] wb_tag_q,  wb_tag_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [EXC_W-1:0]  exc_q,     exc_d;

   // ready_o depends only on the registered occupancy, never on cmpl_ready_i.
   assign ready_o  = (count_s < DEPTH_C);
   assign accept_s = valid_i && ready_o && !flush_i;
   assign wr_s     = dest_valid_i && flags_i[FLAG_EXECUTED];

   cmpl_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_cmpl_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush_i),
      .push_i  (accept_s),
      .data_i  ({al_id_i, flags_i}),
      .pop_i   (cmpl_valid_o && cmpl_ready_i),
      .data_o  (head_s),
      .count_o (count_s)
   );

   assign cmpl_valid_o = (count_s != {CW{1'b0}});
   assign cmpl_al_id_o = head_s[RW-1:FLAGS_W];
   assign cmpl_flags_o = head_s[FLAGS_W-1:0];

   // Next-state for the write/bypass pulse and the saturating exception count.
   always_comb begin
      wb_we_d   = 1'b0;
      wb_tag_d  = wb_tag_q;
      wb_data_d = wb_data_q;
      exc_d     = exc_q;
      if (accept_s && wr_s) begin
         wb_we_d   = 1'b1;
         wb_tag_d  = dest_tag_i;
         wb_data_d = result_i;
      end else begin
         wb_we_d   = 1'b0;
      end
      if (accept_s && flags_i[FLAG_EXCEPTION] && (exc_q != {EXC_W{1'b1}})) begin
         exc_d = exc_q + EXC_W'(1);
      end else begin
         exc_d = exc_q;
      end
   end

   // Write/bypass and exception-count registers; flush kills the pulse but not the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_we_q   <= 1'b0;
         wb_tag_q  <= {PREG_W{1'b0}};
         wb_data_q <= {DATA_W{1'b0}};
         exc_q     <= {EXC_W{1'b0}};
      end else if (flush_i) begin
         wb_we_q   <= 1'b0;
         exc_q     <= exc_q;
      end else begin
         wb_we_q   <= wb_we_d;
         wb_tag_q  <= wb_tag_d;
         wb_data_q <= wb_data_d;
         exc_q     <= exc_d;
      end
   end

   assign rf_we_o     = wb_we_q;
   assign rf_addr_o   = wb_tag_q;
   assign rf_data_o   = wb_data_q;
   assign byp_valid_o = wb_we_q;
   assign byp_tag_o   = wb_tag_q;
   assign byp_data_o  = wb_data_q;
   assign exc_count_o = exc_q;

endmodule
